// File: rtl/vec_mul_sched_if.sv
// Bundle of the scheduler's control, operand-read and result-write signals.
// The slave side is the scheduler; the master side is the host/memory environment.
interface vec_mul_sched_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          start;
  logic [31:0]   n;
  logic          host_we;
  logic          host_gnt;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] acc;
  logic          busy;
  logic          done;

  modport slave (
    input  start, n, host_we, a_q, b_q,
    output host_gnt, rd_en, rd_addr, c_we, c_addr, c_wdata, acc, busy, done
  );

  modport master (
    output start, n, host_we, a_q, b_q,
    input  host_gnt, rd_en, rd_addr, c_we, c_addr, c_wdata, acc, busy, done
  );
endinterface

// File: rtl/vec_mul_sched.sv
// Streams a[i]*b[i] into result memory for i < n and accumulates the dot product.
// Pipeline: rd_en (cycle k) -> operands valid (k+1) -> c_we with product (k+2).
module vec_mul_sched #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  vec_mul_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] NMAX = 32'd1 << AW;

  state_t        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic          drain_q, drain_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          vld1_q, vld1_d;
  logic [AW-1:0] idx1_q, idx1_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [DW-1:0] c_wdata_q, c_wdata_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          busy_q, busy_d;
  logic          host_gnt_q, host_gnt_d;
  logic          done_q, done_d;

  // Next-state for the sequencer and the product/accumulate pipeline.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    drain_d    = drain_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    host_gnt_d = host_gnt_q;
    done_d     = 1'b0;

    vld1_d   = rd_en_q;
    idx1_d   = rd_addr_q;
    c_we_d   = vld1_q;
    c_addr_d = idx1_q;
    if (vld1_q) begin
      c_wdata_d = bus.a_q * bus.b_q;
    end else begin
      c_wdata_d = c_wdata_q;
    end
    if (c_we_q) begin
      acc_d = acc_q + c_wdata_q;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d        = (bus.n > NMAX) ? NMAX[AW:0] : bus.n[AW:0];
          acc_d      = '0;
          busy_d     = 1'b1;
          host_gnt_d = 1'b0;
          if (bus.n == 32'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RUN;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if ({1'b0, rd_addr_q} == n_q - (AW+1)'(1)) begin
          rd_en_d = 1'b0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles let the final product reach c_we and the accumulator.
        if (drain_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        host_gnt_d = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        rd_en_d    = 1'b0;
        busy_d     = 1'b0;
        host_gnt_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      drain_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      vld1_q     <= 1'b0;
      idx1_q     <= '0;
      c_we_q     <= 1'b0;
      c_addr_q   <= '0;
      c_wdata_q  <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      host_gnt_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      vld1_q     <= vld1_d;
      idx1_q     <= idx1_d;
      c_we_q     <= c_we_d;
      c_addr_q   <= c_addr_d;
      c_wdata_q  <= c_wdata_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      host_gnt_q <= host_gnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.host_gnt = host_gnt_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.c_we     = c_we_q;
  assign bus.c_addr   = c_addr_q;
  assign bus.c_wdata  = c_wdata_q;
  assign bus.acc      = acc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_vec_mul_sched.sv
// Directed bench for vec_mul_sched: operand memory model, result capture and
// per-scenario tasks with hand-computed expectations.
module tb_vec_mul_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] a_mem [1024];
  logic [31:0] b_mem [1024];
  logic [31:0] c_mem [1024];
  int          c_cnt, rd_cnt, done_cnt, gnt_bad;
  logic [9:0]  last_rd;

  vec_mul_sched_if #(.AW(10), .DW(32)) bus ();

  vec_mul_sched #(.AW(10), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.a_q <= a_mem[bus.rd_addr];
      bus.b_q <= b_mem[bus.rd_addr];
    end
  end

  // Capture result writes and count strobes mid-cycle.
  always @(negedge clk) begin
    if (bus.c_we === 1'b1) begin
      c_mem[bus.c_addr] <= bus.c_wdata;
      c_cnt <= c_cnt + 1;
    end
    if (bus.rd_en === 1'b1) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= bus.rd_addr;
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (rst === 1'b1 && bus.host_gnt === bus.busy) gnt_bad <= gnt_bad + 1;
  end

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 32'(10 * (i + 1));
      b_mem[i] = 32'(i + 2);
    end
  endtask

  // Issues a start (call #1 after a posedge) and follows the pass to done.
  task automatic do_pass(input logic [31:0] nn, input int bound, output int done_cyc,
                         output int first_rd, output int first_cwe, output logic gnt_c1);
    int cyc;
    done_cyc = -1; first_rd = -1; first_cwe = -1;
    bus.start = 1'b1;
    bus.n     = nn;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.host_we = 1'b0;
    gnt_c1      = bus.host_gnt;
    cyc         = 1;
    while (cyc <= bound) begin
      if (bus.rd_en === 1'b1 && first_rd < 0) first_rd = cyc;
      if (bus.c_we === 1'b1 && first_cwe < 0) first_cwe = cyc;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.n = 32'd0; bus.host_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rd_en !== 1'b0 || bus.c_we !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_strobes: rd_en=%b c_we=%b done=%b required 0", bus.rd_en, bus.c_we, bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.host_gnt !== 1'b1) begin errors++; $display("FAIL reset_busy_gnt: busy=%b gnt=%b required 0/1", bus.busy, bus.host_gnt); end
    checks++; if (bus.acc !== 32'd0 || bus.c_wdata !== 32'd0 || bus.rd_addr !== 10'd0) begin errors++; $display("FAIL reset_data: acc=%0h c_wdata=%0h rd_addr=%0d required 0", bus.acc, bus.c_wdata, bus.rd_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d, fr, fc, c0, g0;
    logic g;
    load_ramp();
    c0 = c_cnt; g0 = gnt_bad;
    bus.host_we = 1'b1;
    do_pass(32'd16, 40, d, fr, fc, g);
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL basic_gnt_after_start: got %b required 0", g); end
    checks++; if (fr !== 1) begin errors++; $display("FAIL basic_first_rd: cycle %0d required 1", fr); end
    checks++; if (fc !== 3) begin errors++; $display("FAIL basic_first_cwe: cycle %0d required 3", fc); end
    checks++; if (d !== 19) begin errors++; $display("FAIL basic_done_cycle: %0d required 19", d); end
    checks++; if (c_cnt - c0 !== 16) begin errors++; $display("FAIL basic_cwe_count: %0d required 16", c_cnt - c0); end
    checks++; if (c_mem[0] !== 32'd20) begin errors++; $display("FAIL basic_c0: %0d required 20", c_mem[0]); end
    checks++; if (c_mem[7] !== 32'd720) begin errors++; $display("FAIL basic_c7: %0d required 720", c_mem[7]); end
    checks++; if (c_mem[15] !== 32'd2720) begin errors++; $display("FAIL basic_c15: %0d required 2720", c_mem[15]); end
    checks++; if (bus.acc !== 32'd16320) begin errors++; $display("FAIL basic_acc: %0d required 16320", bus.acc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.acc !== 32'd16320) begin errors++; $display("FAIL basic_acc_hold: %0d required 16320", bus.acc); end
    checks++; if (bus.busy !== 1'b0 || bus.host_gnt !== 1'b1) begin errors++; $display("FAIL basic_idle: busy=%b gnt=%b required 0/1", bus.busy, bus.host_gnt); end
    checks++; if (gnt_bad - g0 !== 0) begin errors++; $display("FAIL basic_gnt_not_busy: %0d violations required 0", gnt_bad - g0); end
  endtask

  task automatic test_zero();
    int d, fr, fc, c0, r0;
    logic g;
    c0 = c_cnt; r0 = rd_cnt;
    do_pass(32'd0, 10, d, fr, fc, g);
    checks++; if (d !== 1) begin errors++; $display("FAIL zero_done_cycle: %0d required 1", d); end
    checks++; if (bus.acc !== 32'd0) begin errors++; $display("FAIL zero_acc: %0h required 0", bus.acc); end
    @(posedge clk); #1;
    checks++; if (rd_cnt - r0 !== 0 || c_cnt - c0 !== 0) begin errors++; $display("FAIL zero_no_access: rd=%0d cwe=%0d required 0/0", rd_cnt - r0, c_cnt - c0); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: done=%b required 0", bus.done); end
  endtask

  task automatic test_wrap();
    int d, fr, fc;
    logic g;
    a_mem[0] = 32'hFFFF_FFFF;
    b_mem[0] = 32'd2;
    do_pass(32'd1, 20, d, fr, fc, g);
    checks++; if (d !== 4) begin errors++; $display("FAIL wrap_done_cycle: %0d required 4", d); end
    checks++; if (c_mem[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_c0: %0h required fffffffe", c_mem[0]); end
    checks++; if (bus.acc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_acc: %0h required fffffffe", bus.acc); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignored();
    int cyc, d, c0;
    load_ramp();
    c0 = c_cnt; d = -1;
    bus.start = 1'b1; bus.n = 32'd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      bus.start = (cyc == 5);
      if (cyc == 5) bus.n = 32'd4;
      if (bus.done === 1'b1) begin
        d = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++; if (d !== 19) begin errors++; $display("FAIL restart_done_cycle: %0d required 19", d); end
    checks++; if (c_cnt - c0 !== 16) begin errors++; $display("FAIL restart_cwe_count: %0d required 16", c_cnt - c0); end
    checks++; if (bus.acc !== 32'd16320) begin errors++; $display("FAIL restart_acc: %0d required 16320", bus.acc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int d, fr, fc, dn0, c0;
    logic g;
    load_ramp();
    dn0 = done_cnt;
    bus.start = 1'b1; bus.n = 32'd16;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.rd_en !== 1'b0 || bus.c_we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_strobes: rd_en=%b c_we=%b busy=%b done=%b required 0", bus.rd_en, bus.c_we, bus.busy, bus.done); end
    checks++; if (bus.acc !== 32'd0 || bus.host_gnt !== 1'b1) begin errors++; $display("FAIL abort_acc_gnt: acc=%0h gnt=%b required 0/1", bus.acc, bus.host_gnt); end
    c0 = c_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt - dn0 !== 0 || c_cnt - c0 !== 0) begin errors++; $display("FAIL abort_no_done: done=%0d cwe=%0d required 0/0", done_cnt - dn0, c_cnt - c0); end
    c0 = c_cnt;
    do_pass(32'd16, 40, d, fr, fc, g);
    checks++; if (d !== 19 || c_cnt - c0 !== 16) begin errors++; $display("FAIL abort_rerun: done_cycle=%0d cwe=%0d required 19/16", d, c_cnt - c0); end
    checks++; if (bus.acc !== 32'd16320 || c_mem[15] !== 32'd2720) begin errors++; $display("FAIL abort_rerun_data: acc=%0d c15=%0d required 16320/2720", bus.acc, c_mem[15]); end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    int d, fr, fc, r0;
    logic g;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 32'd1;
      b_mem[i] = 32'd1;
    end
    r0 = rd_cnt;
    do_pass(32'd2000, 1100, d, fr, fc, g);
    checks++; if (d !== 1027) begin errors++; $display("FAIL clamp_done_cycle: %0d required 1027", d); end
    checks++; if (rd_cnt - r0 !== 1024 || last_rd !== 10'd1023) begin errors++; $display("FAIL clamp_reads: count=%0d last=%0d required 1024/1023", rd_cnt - r0, last_rd); end
    checks++; if (bus.acc !== 32'd1024) begin errors++; $display("FAIL clamp_acc: %0d required 1024", bus.acc); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    c_cnt = 0; rd_cnt = 0; done_cnt = 0; gnt_bad = 0; last_rd = 10'd0;
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_restart_ignored();
    test_reset_abort();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
